// File: rtl/bitrev_pkg.sv
// -----------------------------------------------------------------------------
// bitrev_pkg
// Shared definitions for the bitrev frame arbiter slice.
//   arb_state_e : input-side arbitration FSM states
//   frame_len() : words per frame for a given log2 frame length
//   owner_w()   : width of a requester index for a given requester count.
//                 Users build their owner type from it:
//                   typedef logic [owner_w(NREQ)-1:0] owner_t;
//                 (a package cannot take parameters, so the width helper is
//                 what carries the parameterisation into each module).
// -----------------------------------------------------------------------------
package bitrev_pkg;

  // Upper bound on the number of requesters the arbiter is built for.
  localparam int MAX_NREQ = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  function automatic int frame_len(input int k);
    return 1 << k;
  endfunction

  function automatic int owner_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/bitrev_tag_fifo.sv
// -----------------------------------------------------------------------------
// bitrev_tag_fifo
// Small synchronous FIFO holding the requester index (tag) of every frame
// admitted into the bitrev core whose output has not yet fully drained.
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset (empties the FIFO)
//   push_i  in   write data_i at the tail (ignored when full)
//   data_i  in   tag to write
//   pop_i   in   drop the head entry (ignored when empty)
//   full_o  out  DEPTH entries held
//   empty_o out  no entries held
//   head_o  out  oldest tag; meaningful only while empty_o is low
// Push and pop in the same cycle leave the occupancy unchanged.
// -----------------------------------------------------------------------------
module bitrev_tag_fifo #(
  parameter int OW    = 2,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [OW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [OW-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [OW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2).
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bitrev_arbiter.sv
// -----------------------------------------------------------------------------
// bitrev_arbiter
// Shares one bitrev core between NREQ streaming requesters at frame
// granularity. The core input port is granted round-robin to one requester
// for a whole N-word frame; the owner of every admitted frame is queued in a
// tag FIFO so the core's output frames are routed back in admission order.
//
// Handshakes: every valid/ready pair transfers a word on a rising clock edge
// where both are high. A valid, once raised, is expected to hold its data
// until ready; ready may depend combinationally on the downstream ready but
// never on the same port's valid.
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset (also the core's reset)
//   req_valid_i  in   [NREQ]     per-requester input word valid
//   req_data_i   in   [NREQ*DW]  per-requester input word, requester r at r*DW
//   req_ready_o  out  [NREQ]     per-requester input ready
//   core_valid_o out             to core valid_i
//   core_data_o  out  [DW]       to core data_i
//   core_ready_i in              from core ready_o
//   core_valid_i in              from core valid_o
//   core_data_i  in   [DW]       from core data_o
//   core_ready_o out             to core ready_i
//   rsp_valid_o  out  [NREQ]     per-requester output word valid
//   rsp_data_o   out  [DW]       output word shared by all requesters
//   rsp_ready_i  in   [NREQ]     per-requester output ready
//   busy_o       out             streaming a frame in, or frames still queued
//   in_owner_o   out  [log2 NREQ] current input owner (0 outside STREAM)
// -----------------------------------------------------------------------------
module bitrev_arbiter
  import bitrev_pkg::*;
#(
  parameter int K          = 10,
  parameter int DW         = 32,
  parameter int NREQ       = 4,
  parameter int MAX_FRAMES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*DW-1:0]     req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   core_valid_o,
  output logic [DW-1:0]          core_data_o,
  input  logic                   core_ready_i,
  input  logic                   core_valid_i,
  input  logic [DW-1:0]          core_data_i,
  output logic                   core_ready_o,
  output logic [NREQ-1:0]        rsp_valid_o,
  output logic [DW-1:0]          rsp_data_o,
  input  logic [NREQ-1:0]        rsp_ready_i,
  output logic                   busy_o,
  output logic [$clog2(NREQ)-1:0] in_owner_o
);

  localparam int OW = owner_w(NREQ);
  localparam logic [K-1:0] LAST_WORD = K'(frame_len(K) - 1);

  typedef logic [OW-1:0] owner_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e   state_q, state_d;
  owner_t       owner_q;
  owner_t       rr_ptr_q;
  logic [K-1:0] in_cnt_q;
  logic [K-1:0] out_cnt_q;

  // Tag FIFO interface
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_full;
  logic   fifo_empty;
  owner_t fifo_head;

  // Arbitration and handshake strobes
  logic   pick_found;
  owner_t pick_idx;
  logic   grant;
  logic   in_hs;
  logic   in_last;
  logic   out_hs;
  logic   out_last;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester at or above rr_ptr, with wrap.
  // Evaluated every cycle but only acted on in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!pick_found && req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input FSM: next state and input-side outputs.
  // In IDLE ready stays low, so req_ready_o never depends on req_valid_i in
  // the same cycle; the grant is registered and costs one bubble per frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    in_hs        = 1'b0;
    req_ready_o  = '0;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    case (state_q)
      IDLE: begin
        // Full FIFO blocks admission even if a pop is in flight this cycle;
        // the grant simply happens one cycle later.
        if (pick_found && !fifo_full) begin
          grant   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        core_valid_o         = req_valid_i[owner_q];
        core_data_o          = req_data_i[int'(owner_q)*DW +: DW];
        req_ready_o[owner_q] = core_ready_i;
        // The owner keeps the grant through valid gaps until word N-1 is taken.
        in_hs = req_valid_i[owner_q] && core_ready_i;
        if (in_hs && (in_cnt_q == LAST_WORD)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_last   = in_hs && (in_cnt_q == LAST_WORD);
  assign fifo_push = grant;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      in_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= pick_idx;
      end
      if (in_hs) begin
        if (in_last) begin
          in_cnt_q <= '0;
          rr_ptr_q <= (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          in_cnt_q <= in_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output routing: the FIFO head owns the core output until N words drain.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_o  = '0;
    core_ready_o = 1'b0;
    out_hs       = 1'b0;
    if (!fifo_empty) begin
      rsp_valid_o[fifo_head] = core_valid_i;
      core_ready_o           = rsp_ready_i[fifo_head];
      out_hs                 = core_valid_i && rsp_ready_i[fifo_head];
    end
  end

  assign out_last   = out_hs && (out_cnt_q == LAST_WORD);
  assign fifo_pop   = out_last;
  assign rsp_data_o = core_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
    end else if (out_hs) begin
      out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
    end
  end

  bitrev_tag_fifo #(
    .OW    (OW),
    .DEPTH (MAX_FRAMES)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (pick_idx),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign busy_o     = (state_q == STREAM) || !fifo_empty;
  assign in_owner_o = (state_q == STREAM) ? owner_q : '0;

endmodule
